// File: rtl/rupt_priority.sv
// ---------------------------------------------------------------------------
// rupt_priority
//
// Latches level interrupt requests and presents the highest-priority pending
// source to the sequencer. Bit 0 of the request vector has the highest
// priority.
//
// Each pending bit is set on any edge where its request is high. It stays
// set until the sequencer accepts that source with krpt. An accepted krpt
// also sets the interrupt-in-progress flag (iip). RESUME (rsm) clears iip.
// INHINT/RELINT pulses set and clear the inhibit flag.
//
// Ports
//   clock      in   system clock; all state changes on its rising edge
//   rst_n      in   synchronous active-low reset
//   rupt_req   in   [9:0] level requests: T6,T5,T3,T4,KEY1,KEY2,UP,DOWN,
//                   RADAR,HND in bit order 0..9
//   inhpls     in   INHINT pulse; sets inhint
//   relpls     in   RELINT pulse; clears inhint (inhpls wins if both occur)
//   mnhrpt     in   monitor inhibit; gates ruptor_n only
//   krpt       in   sequencer is taking the selected interrupt
//   rsm        in   RESUME executed; clears iip
//   ruptor_n   out  low when an interrupt is eligible for service
//   rupt_num   out  [3:0] selected source 1..10, 0 when nothing is pending
//   rupt_addr  out  [11:0] vector address 12'o4000 + 4*rupt_num
//   pend       out  [9:0] pending latches
//   iip        out  interrupt in progress
//   inhint     out  interrupt inhibit flag
//
// Build option
//   HNDRUPT_EN  when defined, rupt_req[9] (HNDRUPT) latches like the other
//               sources. When undefined, pend[9] stays 0 and rupt_req[9]
//               is ignored; the port list is identical in both builds.
// ---------------------------------------------------------------------------
module rupt_priority (
    input  logic        clock,
    input  logic        rst_n,
    input  logic [9:0]  rupt_req,
    input  logic        inhpls,
    input  logic        relpls,
    input  logic        mnhrpt,
    input  logic        krpt,
    input  logic        rsm,
    output logic        ruptor_n,
    output logic [3:0]  rupt_num,
    output logic [11:0] rupt_addr,
    output logic [9:0]  pend,
    output logic        iip,
    output logic        inhint
);

    localparam logic [11:0] VEC_BASE = 12'o4000;

    logic [9:0] req_eff;
    logic [9:0] clr_mask;
    logic       take;
    logic       any_pend;

`ifdef HNDRUPT_EN
    assign req_eff = rupt_req;
`else
    // HNDRUPT is absent in this build: its request line is kept on the port
    // for drop-in compatibility but never reaches the pending latch.
    logic unused_hnd_req;
    assign unused_hnd_req = rupt_req[9];
    assign req_eff        = {1'b0, rupt_req[8:0]};
`endif

    // Priority select: lowest-numbered pending bit wins.
    always_comb begin
        logic found;
        rupt_num = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (pend[i] && !found) begin
                rupt_num = 4'(i + 1);
                found    = 1'b1;
            end
        end
    end

    assign any_pend  = |pend;
    assign ruptor_n  = ~(any_pend & ~inhint & ~iip & ~mnhrpt);
    assign rupt_addr = VEC_BASE + {6'b0, rupt_num, 2'b00};

    // krpt only counts while an interrupt is actually eligible.
    assign take = krpt & ~ruptor_n;

    always_comb begin
        clr_mask = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            clr_mask[i] = take && (rupt_num == 4'(i + 1));
        end
    end

    // A request on the bit being cleared re-sets it in the same edge.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            pend   <= '0;
            iip    <= 1'b0;
            inhint <= 1'b1;
        end else begin
            pend   <= (pend & ~clr_mask) | req_eff;
            iip    <= take | (iip & ~rsm);
            inhint <= inhpls | (inhint & ~relpls);
        end
    end

endmodule

// File: tb/tb_rupt_priority.sv
module tb_rupt_priority;

    logic        clock = 1'b0;
    logic        rst_n;
    logic [9:0]  rupt_req;
    logic        inhpls, relpls, mnhrpt, krpt, rsm;
    logic        ruptor_n;
    logic [3:0]  rupt_num;
    logic [11:0] rupt_addr;
    logic [9:0]  pend;
    logic        iip, inhint;

    rupt_priority dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .rupt_req  (rupt_req),
        .inhpls    (inhpls),
        .relpls    (relpls),
        .mnhrpt    (mnhrpt),
        .krpt      (krpt),
        .rsm       (rsm),
        .ruptor_n  (ruptor_n),
        .rupt_num  (rupt_num),
        .rupt_addr (rupt_addr),
        .pend      (pend),
        .iip       (iip),
        .inhint    (inhint)
    );

    always #5 clock = ~clock;

    typedef struct {
        int pend;
        int num;
        int addr;
        int ruptor_n;
        int iip;
        int inhint;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference state: which sources are waiting, and the two flags.
    bit   m_wait[10];
    bit   m_iip;
    bit   m_inh;

    function automatic int top_source();
        for (int s = 1; s <= 10; s++)
            if (m_wait[s-1]) return s;
        return 0;
    endfunction

    function automatic bit any_waiting();
        for (int s = 0; s < 10; s++)
            if (m_wait[s]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int wait_vec();
        int v = 0;
        for (int s = 0; s < 10; s++)
            if (m_wait[s]) v += (1 << s);
        return v;
    endfunction

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, expv, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model across
    // the next rising edge and queue what the outputs must then show.
    task automatic step(input int req, input bit ih, input bit rl, input bit mn,
                        input bit kr, input bit rs, input bit rst);
        bit   eligible, accept;
        int   src;
        exp_t e;
        @(negedge clock);
        rupt_req = 10'(req);
        inhpls   = ih;
        relpls   = rl;
        mnhrpt   = mn;
        krpt     = kr;
        rsm      = rs;
        rst_n    = ~rst;

        eligible = any_waiting() && !m_inh && !m_iip && !mn;
        if (rst) begin
            foreach (m_wait[s]) m_wait[s] = 1'b0;
            m_iip = 1'b0;
            m_inh = 1'b1;
        end else begin
            accept = kr && eligible;
            src    = top_source();
            if (accept) m_wait[src-1] = 1'b0;
            for (int s = 0; s < 10; s++) begin
`ifdef HNDRUPT_EN
                if (req[s]) m_wait[s] = 1'b1;
`else
                if (req[s] && s != 9) m_wait[s] = 1'b1;
`endif
            end
            if (accept)  m_iip = 1'b1;
            else if (rs) m_iip = 1'b0;
            if (ih)      m_inh = 1'b1;
            else if (rl) m_inh = 1'b0;
        end

        e.pend     = wait_vec();
        e.num      = top_source();
        e.addr     = 2048 + 4 * e.num;
        e.ruptor_n = (any_waiting() && !m_inh && !m_iip && !mn) ? 0 : 1;
        e.iip      = m_iip;
        e.inhint   = m_inh;
        q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle, just after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pend",      int'(pend),      e.pend);
                chk("rupt_num",  int'(rupt_num),  e.num);
                chk("rupt_addr", int'(rupt_addr), e.addr);
                chk("ruptor_n",  int'(ruptor_n),  e.ruptor_n);
                chk("iip",       int'(iip),       e.iip);
                chk("inhint",    int'(inhint),    e.inhint);
            end
        end
    end

    initial begin
        rupt_req = '0; inhpls = 0; relpls = 0; mnhrpt = 0;
        krpt = 0; rsm = 0; rst_n = 0;
        foreach (m_wait[s]) m_wait[s] = 1'b0;
        m_iip = 1'b0;
        m_inh = 1'b1;

        //    req            ih rl mn kr rs rst
        step(0,              0, 0, 0, 0, 0, 1);
        step(0,              0, 0, 0, 0, 0, 1);
        // single T4 request
        step(0,              0, 1, 0, 0, 0, 0);
        step(10'b0000001000, 0, 0, 0, 0, 0, 0);
        step(0,              0, 0, 0, 0, 0, 0);
        step(0,              0, 0, 0, 1, 0, 0);
        step(0,              0, 0, 0, 0, 1, 0);
        // two simultaneous requests, serviced in priority order
        step(10'b0010000100, 0, 0, 0, 0, 0, 0);
        step(0,              0, 0, 0, 1, 0, 0);
        step(0,              0, 0, 0, 1, 0, 0);   // ignored: iip set
        step(0,              0, 0, 0, 0, 1, 0);
        step(0,              0, 0, 1, 1, 0, 0);   // ignored: mnhrpt
        step(0,              0, 0, 0, 1, 0, 0);
        step(0,              0, 0, 0, 0, 1, 0);
        // inhibit after reset blocks service
        step(0,              0, 0, 0, 0, 0, 1);
        step(10'b0000000001, 0, 0, 0, 0, 0, 0);
        step(0,              0, 0, 0, 1, 0, 0);
        step(0,              0, 1, 0, 0, 0, 0);
        step(0,              1, 1, 0, 0, 0, 0);
        step(0,              0, 1, 0, 1, 0, 0);
        step(0,              0, 0, 0, 0, 1, 0);
        // set wins over clear, krpt+rsm keeps iip
        step(10'b0000010000, 0, 0, 0, 0, 0, 0);
        step(10'b0000010000, 0, 0, 0, 1, 0, 0);
        step(0,              0, 0, 0, 0, 1, 0);
        step(0,              0, 0, 0, 1, 1, 0);
        step(0,              0, 0, 0, 0, 1, 0);
        // reset mid-service with everything pending and requests present
        step(10'h3FF,        0, 0, 0, 0, 0, 0);
        step(0,              0, 0, 0, 1, 0, 0);
        step(10'h3FF,        0, 0, 0, 0, 0, 1);
        step(0,              0, 0, 0, 0, 0, 0);
        // HNDRUPT alone
        step(0,              0, 1, 0, 0, 0, 0);
        step(10'b1000000000, 0, 0, 0, 0, 0, 0);
        step(0,              0, 0, 0, 1, 0, 0);
        step(0,              0, 0, 0, 0, 1, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r = 0;
            for (int b = 0; b < 10; b++)
                if ($urandom_range(0, 99) < 6) r += (1 << b);
            step(r,
                 $urandom_range(0, 99) < 6,
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 35,
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 199) < 2);
        end

        repeat (3) @(posedge clock);
        #2;
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rupt_priority.md
RUPT_PRIORITY -- requirements
Module: rupt_priority

Interface
REQ-001 SHALL have port clock, input, 1: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-003 SHALL have port rupt_req, input, 10: level interrupt requests, sampled every edge. Bit0=T6RUPT, bit1=T5RUPT, bit2=T3RUPT, bit3=T4RUPT, bit4=KEYRUPT1, bit5=KEYRUPT2, bit6=UPRUPT, bit7=DOWNRUPT, bit8=RADARUPT, bit9=HNDRUPT.
REQ-004 SHALL have port inhpls, input, 1: INHINT pulse; sets the inhibit flag.
REQ-005 SHALL have port relpls, input, 1: RELINT pulse; clears the inhibit flag.
REQ-006 SHALL have port mnhrpt, input, 1: monitor interrupt inhibit; gates ruptor_n only.
REQ-007 SHALL have port krpt, input, 1: one-cycle strobe; the sequencer is taking the selected interrupt.
REQ-008 SHALL have port rsm, input, 1: one-cycle strobe; RESUME executed.
REQ-009 SHALL have port ruptor_n, output, 1: low = interrupt eligible. Feeds the SQ register.
REQ-010 SHALL have port rupt_num, output, 4: selected source number 1..10; 0 = none pending.
REQ-011 SHALL have port rupt_addr, output, 12: vector address, 12'o4000 + 4*rupt_num; 12'o4000 when rupt_num=0.
REQ-012 SHALL have port pend, output, 10: pending latches.
REQ-013 SHALL have ports iip and inhint, output, 1 each: interrupt-in-progress flag and inhibit flag.

Function
REQ-014 Each pend[i] SHALL be set at any edge where rupt_req[i]=1. It SHALL hold until cleared by REQ-018.
REQ-015 rupt_num SHALL be combinational from pend: (lowest set bit index)+1. Bit0 has highest priority.
REQ-016 ruptor_n SHALL be combinational from registers: 0 iff pend!=0 and inhint=0 and iip=0 and mnhrpt=0. Latency from rupt_req assertion to ruptor_n low SHALL be one edge.
REQ-017 A krpt with ruptor_n=1 SHALL be ignored: no state change.
REQ-018 A krpt with ruptor_n=0 SHALL, at that edge, clear pend[rupt_num-1] and set iip.
REQ-019 If the bit being cleared has rupt_req high in the same cycle, the bit SHALL remain 1 (set wins). Other pending bits SHALL be unaffected.
REQ-020 rsm SHALL clear iip. If krpt (accepted) and rsm occur in the same cycle, iip SHALL be 1.
REQ-021 inhpls SHALL set inhint and relpls SHALL clear it. If both occur in the same cycle, inhint SHALL be 1.
REQ-022 inhint, iip and mnhrpt SHALL NOT block latching of new requests.
REQ-023 Two or more requests arriving in the same cycle SHALL all latch. They SHALL then be serviced one per accepted krpt, in priority order.

Reset
REQ-024 On an edge with rst_n=0: pend=0, iip=0, inhint=1. The resulting outputs SHALL be ruptor_n=1, rupt_num=0, rupt_addr=12'o4000.
REQ-025 Reset SHALL override all other inputs on the same edge, including mid-service (iip=1) and requests present at that edge.

Configuration
REQ-026 Macro HNDRUPT_EN: when defined, rupt_req[9] SHALL behave per REQ-014.
REQ-027 When HNDRUPT_EN is undefined:
- pend[9] SHALL be held at 0 and rupt_req[9] ignored.
- rupt_num SHALL never exceed 9.
- The port list SHALL be unchanged.

Verification
REQ-028 Reset, then relpls, then rupt_req=10'b0000001000 for one cycle -> next cycle: pend[3]=1, rupt_num=4, rupt_addr=12'o4020, ruptor_n=0.
REQ-029 rupt_req=10'b0010000100 in one cycle, with inhint=0 -> rupt_num=3. Then krpt -> pend=10'b0010000000, iip=1, ruptor_n=1. Then rsm -> rupt_num=8, ruptor_n=0.
REQ-030 inhint=1 (after reset) with pend[0] set -> ruptor_n=1. krpt -> no change. relpls -> ruptor_n=0. Same cycle inhpls+relpls -> inhint=1.
REQ-031 krpt for source 5 while rupt_req[4]=1 in the same cycle -> pend[4] stays 1 and iip=1. krpt+rsm together -> iip=1.
REQ-032 iip=1, pend=10'h3FF, rst_n=0 for one edge -> pend=0, iip=0, inhint=1, ruptor_n=1.
REQ-033 rupt_req[9] pulse alone -> with HNDRUPT_EN: rupt_num=10, rupt_addr=12'o4050. Without HNDRUPT_EN: pend=0, rupt_num=0.
